// File: rtl/iob_sp_ram_ctrl_pkg.sv
// Shared definitions for the single-port RAM controller: state encoding and
// the state enum. The RMW_WR state only exists when IOB_SP_RAM_CTRL_RMW_EN
// is defined.
package iob_sp_ram_ctrl_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_RD      = 3'd1;
  localparam logic [ST_W-1:0] ST_RD_WAIT = 3'd2;
  localparam logic [ST_W-1:0] ST_WR      = 3'd3;
`ifdef IOB_SP_RAM_CTRL_RMW_EN
  localparam logic [ST_W-1:0] ST_RMW_WR  = 3'd4;
`endif
  localparam logic [ST_W-1:0] ST_RESP    = 3'd5;

  typedef enum logic [ST_W-1:0] {
    IDLE    = ST_IDLE,
    RD      = ST_RD,
    RD_WAIT = ST_RD_WAIT,
    WR      = ST_WR,
`ifdef IOB_SP_RAM_CTRL_RMW_EN
    RMW_WR  = ST_RMW_WR,
`endif
    RESP    = ST_RESP
  } state_t;

endpackage

// File: rtl/iob_strb_merge.sv
// Byte-lane merge: each byte comes from new_data where its strobe is set,
// otherwise from old_data. Purely combinational.
module iob_strb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] strb,
  output logic [DATA_W-1:0]   merged
);

  // Start from the old word and overwrite the strobed byte lanes.
  always_comb begin
    merged = old_data;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/iob_sp_ram_ctrl.sv
// Single-port synchronous RAM controller. One request is accepted in IDLE,
// its fields are latched, and a fixed-latency sequence drives the RAM.
// Fixed latencies (accepting edge to ready cycle): read 3, full write 2,
// read-modify-write 4.
// Handshake: valid is sampled only in IDLE; the request is accepted on that
// rising edge and all other inputs are ignored until IDLE is reached again.
// ready is a single-cycle completion pulse; rdata is valid while ready=1 and
// held until the next read capture.
// Build option: define IOB_SP_RAM_CTRL_RMW_EN for partial-strobe
// read-modify-write; otherwise any nonzero strobe is a full-word write.
module iob_sp_ram_ctrl
  import iob_sp_ram_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout,
  output logic [ST_W-1:0]     dbg_state
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                accept;

  assign accept = (state_q == IDLE) && valid;

`ifdef IOB_SP_RAM_CTRL_RMW_EN
  localparam int STRB_W = DATA_W / 8;

  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                rmw_q, rmw_d;
  logic [DATA_W-1:0]   merged;

  iob_strb_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_data (rdata_q),
    .new_data (wdata_q),
    .strb     (strb_q),
    .merged   (merged)
  );
`endif

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: read, full write or (optionally) read-modify-write sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          if (wstrb == '0) state_d = RD;
`ifdef IOB_SP_RAM_CTRL_RMW_EN
          else if (&wstrb) state_d = WR;
          else             state_d = RD;
`else
          else             state_d = WR;
`endif
        end
      end
      RD:      state_d = RD_WAIT;
`ifdef IOB_SP_RAM_CTRL_RMW_EN
      RD_WAIT: state_d = rmw_q ? RMW_WR : RESP;
      RMW_WR:  state_d = RESP;
`else
      RD_WAIT: state_d = RESP;
`endif
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: decoded from state and latched request fields only.
  always_comb begin
    ready   = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    ram_din = wdata_q;
    unique case (state_q)
      RD: ram_en = 1'b1;
      WR: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
`ifdef IOB_SP_RAM_CTRL_RMW_EN
      RMW_WR: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        ram_din = merged;
      end
`endif
      RESP:    ready = 1'b1;
      default: ;
    endcase
  end

  // Request latches load on acceptance; read data loads in RD_WAIT.
  always_comb begin
    addr_d  = accept ? addr  : addr_q;
    wdata_d = accept ? wdata : wdata_q;
    rdata_d = (state_q == RD_WAIT) ? ram_dout : rdata_q;
  end

`ifdef IOB_SP_RAM_CTRL_RMW_EN
  // Strobe latch and RMW flag (partial, nonzero strobe).
  always_comb begin
    strb_d = accept ? wstrb : strb_q;
    rmw_d  = accept ? ((wstrb != '0) && !(&wstrb)) : rmw_q;
  end

  // RMW request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_q <= '0;
      rmw_q  <= 1'b0;
    end else begin
      strb_q <= strb_d;
      rmw_q  <= rmw_d;
    end
  end
`endif

  // Datapath registers; cleared so every RAM-side output reads 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_addr  = addr_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_iob_sp_ram_ctrl.sv
// Directed bench for iob_sp_ram_ctrl paired with a behavioural 32-bit
// single-port RAM (one-cycle read latency). Expectations for partial strobes
// follow IOB_SP_RAM_CTRL_RMW_EN.
module tb_iob_sp_ram_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [3:0]        wstrb = '0;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic [2:0]        dbg_state;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int                wr_cnt = 0;
  int                tests = 0;
  int                fails = 0;

  iob_sp_ram_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .rdata     (rdata),
    .ready     (ready),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural single-port RAM with write counter
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_din;
        wr_cnt        <= wr_cnt + 1;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  // One request; lat = cycle index of ready (accept edge = 0), rdy_after = ready one cycle later
  task automatic do_req(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int lat, output logic [31:0] rd, output logic rdy_after);
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1;
    while (ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    @(posedge clk); #1;
    rdy_after = ready;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (ready !== 1'b0)     begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
    tests++; if (rdata !== 32'h0)    begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    tests++; if (ram_en !== 1'b0)    begin fails++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
    tests++; if (ram_we !== 1'b0)    begin fails++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
    tests++; if (ram_addr !== 14'h0) begin fails++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
    tests++; if (ram_din !== 32'h0)  begin fails++; $display("FAIL reset_ram_din: got %h expected 0", ram_din); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_write();
    int lat; logic [31:0] rd; logic ra; int w0;
    w0 = wr_cnt;
    do_req(14'h010, 32'hDEADBEEF, 4'hF, lat, rd, ra);
    tests++; if (lat !== 2) begin fails++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    tests++; if (mem[14'h010] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_mem: got %h expected deadbeef", mem[14'h010]); end
    tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL wr_count: got %0d expected 1", wr_cnt - w0); end
    tests++; if (ra !== 1'b0) begin fails++; $display("FAIL wr_ready_pulse: got %b expected 0", ra); end
    w0 = wr_cnt;
    do_req(14'h010, 32'h0, 4'h0, lat, rd, ra);
    tests++; if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL rd_no_write: got %0d expected 0", wr_cnt - w0); end
    tests++; if (ra !== 1'b0) begin fails++; $display("FAIL rd_ready_pulse: got %b expected 0", ra); end
    tests++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_hold: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_rmw();
    int lat; logic [31:0] rd; logic ra; int w0; int exp_lat; logic [31:0] exp_d;
`ifdef IOB_SP_RAM_CTRL_RMW_EN
    exp_lat = 4; exp_d = 32'h11BB33DD;
`else
    exp_lat = 2; exp_d = 32'hAABBCCDD;
`endif
    do_req(14'h020, 32'h11223344, 4'hF, lat, rd, ra);
    w0 = wr_cnt;
    do_req(14'h020, 32'hAABBCCDD, 4'h5, lat, rd, ra);
    tests++; if (lat !== exp_lat) begin fails++; $display("FAIL rmw_latency: got %0d expected %0d", lat, exp_lat); end
    tests++; if (mem[14'h020] !== exp_d) begin fails++; $display("FAIL rmw_mem: got %h expected %h", mem[14'h020], exp_d); end
    tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL rmw_write_count: got %0d expected 1", wr_cnt - w0); end
    do_req(14'h020, 32'h0, 4'h0, lat, rd, ra);
    tests++; if (rd !== exp_d) begin fails++; $display("FAIL rmw_readback: got %h expected %h", rd, exp_d); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic ra; int t; int np;
    int pt [3];
    logic [31:0] pd [3];
    logic [31:0] exp_v [3];
    exp_v[0] = 32'h00001111; exp_v[1] = 32'h22220000; exp_v[2] = 32'h33334444;
    for (int i = 0; i < 3; i++) begin
      pt[i] = -100; pd[i] = 32'h0;
      do_req(ADDR_W'(i), exp_v[i], 4'hF, lat, rd, ra);
    end
    @(negedge clk);
    valid = 1'b1; addr = 14'h000; wstrb = 4'h0; wdata = 32'h0;
    @(posedge clk); #1;
    t = 0; np = 0;
    while (np < 3 && t < 40) begin
      if (ready === 1'b1) begin
        pt[np] = t; pd[np] = rdata; np++;
        if (np < 3) addr = ADDR_W'(np);
        else        valid = 1'b0;
      end
      @(posedge clk); #1;
      t++;
    end
    valid = 1'b0;
    tests++; if (np !== 3) begin fails++; $display("FAIL b2b_pulses: got %0d expected 3", np); end
    tests++; if (pt[0] !== 2) begin fails++; $display("FAIL b2b_first_pulse: got %0d expected 2", pt[0]); end
    tests++; if (pt[1] - pt[0] !== 4) begin fails++; $display("FAIL b2b_gap1: got %0d expected 4", pt[1] - pt[0]); end
    tests++; if (pt[2] - pt[1] !== 4) begin fails++; $display("FAIL b2b_gap2: got %0d expected 4", pt[2] - pt[1]); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (pd[i] !== exp_v[i]) begin fails++; $display("FAIL b2b_data%0d: got %h expected %h", i, pd[i], exp_v[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic ra; int w0; logic saw;
    do_req(14'h030, 32'h55667788, 4'hF, lat, rd, ra);
    w0 = wr_cnt;
    @(negedge clk);
    valid = 1'b1; addr = 14'h030; wdata = 32'h99AABBCC; wstrb = 4'h3;
    @(posedge clk); #1;
    valid = 1'b0;
`ifdef IOB_SP_RAM_CTRL_RMW_EN
    @(posedge clk); #1;
    tests++; if (dbg_state !== 3'd2) begin fails++; $display("FAIL abort_in_rd_wait: got %0d expected 2", dbg_state); end
`endif
    rst = 1'b1;
    #1;
    tests++; if (ready !== 1'b0)     begin fails++; $display("FAIL abort_ready: got %b expected 0", ready); end
    tests++; if (rdata !== 32'h0)    begin fails++; $display("FAIL abort_rdata: got %h expected 0", rdata); end
    tests++; if (ram_en !== 1'b0)    begin fails++; $display("FAIL abort_ram_en: got %b expected 0", ram_en); end
    tests++; if (ram_we !== 1'b0)    begin fails++; $display("FAIL abort_ram_we: got %b expected 0", ram_we); end
    tests++; if (ram_addr !== 14'h0) begin fails++; $display("FAIL abort_ram_addr: got %h expected 0", ram_addr); end
    tests++; if (ram_din !== 32'h0)  begin fails++; $display("FAIL abort_ram_din: got %h expected 0", ram_din); end
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready === 1'b1) saw = 1'b1;
    end
    // Release reset and request in the same cycle: first edge must accept.
    @(negedge clk);
    rst = 1'b0; valid = 1'b1; addr = 14'h030; wstrb = 4'h0; wdata = 32'h0;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1;
    while (ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    @(posedge clk); #1;
    tests++; if (saw !== 1'b0) begin fails++; $display("FAIL abort_no_ready: got %b expected 0", saw); end
    tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL abort_no_write: got %0d expected 0", wr_cnt - w0); end
    tests++; if (mem[14'h030] !== 32'h55667788) begin fails++; $display("FAIL abort_mem: got %h expected 55667788", mem[14'h030]); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL post_reset_accept: got %0d expected 3", lat); end
    tests++; if (rd !== 32'h55667788) begin fails++; $display("FAIL post_reset_read: got %h expected 55667788", rd); end
  endtask

  task automatic test_top_addr();
    int lat; logic [31:0] rd; logic ra;
    do_req(14'h3FFF, 32'hCAFEF00D, 4'hF, lat, rd, ra);
    tests++; if (mem[14'h3FFF] !== 32'hCAFEF00D) begin fails++; $display("FAIL top_mem: got %h expected cafef00d", mem[14'h3FFF]); end
    tests++; if (mem[14'h0000] !== 32'h00001111) begin fails++; $display("FAIL top_no_alias: got %h expected 00001111", mem[14'h0000]); end
    do_req(14'h3FFF, 32'h0, 4'h0, lat, rd, ra);
    tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL top_read: got %h expected cafef00d", rd); end
    do_req(14'h0000, 32'h0, 4'h0, lat, rd, ra);
    tests++; if (rd !== 32'h00001111) begin fails++; $display("FAIL top_read_zero: got %h expected 00001111", rd); end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Sequence and report
  initial begin
    test_reset();
    test_full_write();
    test_rmw();
    test_back_to_back();
    test_reset_abort();
    test_top_addr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
